fir_frame_sequencer: RTL and testbench

//  Frame/row sequencer for the free-running 12-bit fir datapath in image mode.

---
 rtl/fir_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fir_frame_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_frame_sequencer.sv
// Row/frame sequencer wrapping a free-running 12-bit FIR: feeds pixels, inserts per-row zero
// flush samples, and realigns the FIR output through a tag pipe so only real pixels are emitted.
module fir_frame_sequencer #(
   parameter int unsigned IMG_W   = 512,
   parameter int unsigned IMG_H   = 512,
   parameter int unsigned FLUSH   = 7,
   parameter int unsigned FIR_LAT = 7
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [7:0]  px_data,
   input  logic        px_valid,
   output logic        px_ready,
   output logic [11:0] X_in,
   input  logic [11:0] Y_out,
   output logic [11:0] out_data,
   output logic        out_valid,
   output logic        out_eol,
   output logic        out_eof,
   output logic        busy,
   output logic        done,
   output logic        err_underrun
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [FW-1:0] FCNT_LAST = FW'(FLUSH - 1);

   typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_t;

   typedef struct packed {
      logic v;
      logic eol;
      logic eof;
   } tag_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [FW-1:0] fcnt;
   logic          eof_seen;
   tag_t          tags [FIR_LAT+1];

   logic          last_col;
   logic          last_row;

   assign last_col = (col == COL_LAST);
   assign last_row = (row == ROW_LAST);

   always_ff @(posedge clk) begin
      if (Reset) begin
         state        <= StIdle;
         col          <= '0;
         row          <= '0;
         fcnt         <= '0;
         eof_seen     <= 1'b0;
         X_in         <= '0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         out_eol      <= 1'b0;
         out_eof      <= 1'b0;
         px_ready     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_underrun <= 1'b0;
         for (int k = 0; k <= FIR_LAT; k++) begin
            tags[k] <= '0;
         end
      end else begin
         done <= 1'b0;

         // Tag at the last stage lines up with the FIR output for the same sample.
         if (tags[FIR_LAT].v) begin
            out_data  <= Y_out;
            out_valid <= 1'b1;
            out_eol   <= tags[FIR_LAT].eol;
            out_eof   <= tags[FIR_LAT].eof;
            if (tags[FIR_LAT].eof) begin
               eof_seen <= 1'b1;
            end
         end else begin
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
         end

         for (int k = 1; k <= FIR_LAT; k++) begin
            tags[k] <= tags[k-1];
         end
         tags[0] <= '0;
         X_in    <= '0;

         unique case (state)
            StIdle: begin
               if (start) begin
                  state        <= StFeed;
                  col          <= '0;
                  row          <= '0;
                  fcnt         <= '0;
                  eof_seen     <= 1'b0;
                  err_underrun <= 1'b0;
                  px_ready     <= 1'b1;
                  busy         <= 1'b1;
               end
            end

            StFeed: begin
               if (px_valid) begin
                  X_in    <= {4'b0, px_data};
                  tags[0] <= '{v: 1'b1, eol: last_col, eof: last_col && last_row};
                  if (last_col) begin
                     col      <= '0;
                     fcnt     <= '0;
                     state    <= StFlush;
                     px_ready <= 1'b0;
                  end else begin
                     col <= col + 1'b1;
                  end
               end else begin
                  err_underrun <= 1'b1;
               end
            end

            StFlush: begin
               fcnt <= fcnt + 1'b1;
               if (fcnt == FCNT_LAST) begin
                  fcnt <= '0;
                  if (last_row) begin
                     state <= StDrain;
                  end else begin
                     row      <= row + 1'b1;
                     state    <= StFeed;
                     px_ready <= 1'b1;
                  end
               end
            end

            StDrain: begin
               // eof_seen is sticky, so a long flush that outlasts the pipe still terminates.
               if (done) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end else if (eof_seen) begin
                  done <= 1'b1;
               end
            end

            default: begin
               state    <= StIdle;
               px_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Directed bench for fir_frame_sequencer on a 4x2 frame, FLUSH=3, with a pure-delay FIR stub.
module tb_fir_frame_sequencer;

   localparam int unsigned W = 4;
   localparam int unsigned H = 2;
   localparam int unsigned F = 3;
   localparam int unsigned L = 7;

   logic        clk = 1'b0;
   logic        Reset;
   logic        start;
   logic [7:0]  px_data;
   logic        px_valid;
   logic        px_ready;
   logic [11:0] X_in;
   logic [11:0] Y_out;
   logic [11:0] out_data;
   logic        out_valid;
   logic        out_eol;
   logic        out_eof;
   logic        busy;
   logic        done;
   logic        err_underrun;

   always #5 clk = ~clk;

   fir_frame_sequencer #(
      .IMG_W   (W),
      .IMG_H   (H),
      .FLUSH   (F),
      .FIR_LAT (L)
   ) dut (
      .clk          (clk),
      .Reset        (Reset),
      .start        (start),
      .px_data      (px_data),
      .px_valid     (px_valid),
      .px_ready     (px_ready),
      .X_in         (X_in),
      .Y_out        (Y_out),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_eol      (out_eol),
      .out_eof      (out_eof),
      .busy         (busy),
      .done         (done),
      .err_underrun (err_underrun)
   );

   // FIR stub: pure L-cycle delay of X_in.
   logic [11:0] dly [L];
   always_ff @(posedge clk) begin
      dly[0] <= X_in;
      for (int k = 1; k < L; k++) dly[k] <= dly[k-1];
   end
   assign Y_out = dly[L-1];

   int n_assert = 0;
   int n_fail   = 0;

   logic [11:0] xlog  [$];
   logic [11:0] odata [$];
   logic        oeol  [$];
   logic        oeof  [$];
   int          first_acc, first_out, done_cnt, busy_cnt, flag_bad;
   bit          fin;

   int exp_x1 [$] = '{0, 0, 1, 2, 3, 4, 0, 0, 0, 5, 6, 7, 8, 0, 0, 0};
   int exp_x2 [$] = '{0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 5, 6, 7, 8, 0, 0, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Cycle 0 pulses start; runs until done (then one more edge) or until stop_px pixels accepted.
   task automatic run_frame(input int gap_px, input int gap_len, input int st_a, input int st_b,
                            input int stop_px);
      int nxt  = 1;
      int gaps = 0;
      bit acc;
      xlog.delete(); odata.delete(); oeol.delete(); oeof.delete();
      first_acc = -1; first_out = -1; done_cnt = 0; busy_cnt = 0; flag_bad = 0; fin = 0;
      for (int c = 0; c < 200 && !fin; c++) begin
         start    = (c == 0) || (c == st_a) || (c == st_b);
         px_data  = nxt[7:0];
         px_valid = 1'b1;
         if (nxt == gap_px && gaps < gap_len && px_ready) begin
            px_valid = 1'b0;
            gaps++;
         end
         xlog.push_back(X_in);
         if (out_valid) begin
            odata.push_back(out_data);
            oeol.push_back(out_eol);
            oeof.push_back(out_eof);
            if (first_out < 0) first_out = c;
         end else if (out_eol || out_eof) begin
            flag_bad++;
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            fin = 1;
         end
         acc = px_ready && px_valid;
         if (acc && first_acc < 0) first_acc = c;
         @(posedge clk);
         #1;
         if (acc) nxt++;
         if (stop_px > 0 && nxt > stop_px) fin = 1;
      end
      start = 1'b0;
      chk("frame_terminated", 32'(fin), 1);
   endtask

   task automatic check_frame(input string nm, input int ex [$], input int exp_busy);
      chk({nm, "_out_count"}, odata.size(), 8);
      for (int i = 0; i < odata.size() && i < 8; i++) begin
         chk($sformatf("%s_data%0d", nm, i), odata[i], i + 1);
         chk($sformatf("%s_eol%0d", nm, i), oeol[i], (i == 3 || i == 7) ? 1 : 0);
         chk($sformatf("%s_eof%0d", nm, i), oeof[i], (i == 7) ? 1 : 0);
      end
      for (int i = 0; i < ex.size(); i++) begin
         if (i < xlog.size()) chk($sformatf("%s_xin%0d", nm, i), xlog[i], ex[i]);
         else chk($sformatf("%s_xin_len", nm), xlog.size(), ex.size());
      end
      chk({nm, "_latency"}, first_out - first_acc, 9);
      chk({nm, "_done_cnt"}, done_cnt, 1);
      chk({nm, "_busy_cycles"}, busy_cnt, exp_busy);
      chk({nm, "_flags_without_valid"}, flag_bad, 0);
   endtask

   initial begin
      int seen_done, seen_valid;
      Reset    = 1'b1;
      start    = 1'b0;
      px_valid = 1'b0;
      px_data  = 8'd0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_px_ready", px_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_x_in", X_in, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_underrun, 0);
      Reset = 1'b0;

      // 1: gapless frame
      run_frame(0, 0, -1, -1, 0);
      check_frame("t1", exp_x1, 21);
      chk("t1_err", err_underrun, 0);
      chk("t1_idle_after_done", busy, 0);

      // 2: two-cycle underrun before pixel 3
      run_frame(3, 2, -1, -1, 0);
      check_frame("t2", exp_x2, 23);
      chk("t2_err_set", err_underrun, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t2_err_sticky", err_underrun, 1);

      // 3: reset after pixel 6 of row 2
      run_frame(0, 0, -1, -1, 6);
      chk("t3_err_cleared_by_start", err_underrun, 0);
      chk("t3_busy_before_reset", busy, 1);
      Reset = 1'b1;
      @(posedge clk);
      #1;
      Reset = 1'b0;
      chk("t3_busy", busy, 0);
      chk("t3_out_valid", out_valid, 0);
      chk("t3_x_in", X_in, 0);
      chk("t3_px_ready", px_ready, 0);
      seen_done  = 0;
      seen_valid = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) seen_done++;
         if (out_valid) seen_valid++;
         @(posedge clk);
         #1;
      end
      chk("t3_no_done", seen_done, 0);
      chk("t3_no_valid", seen_valid, 0);
      run_frame(0, 0, -1, -1, 0);
      check_frame("t3r", exp_x1, 21);

      // 4: start pulsed in FEED (cycle 3) and DRAIN (cycle 17) is ignored
      run_frame(0, 0, 3, 17, 0);
      check_frame("t4", exp_x1, 21);
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) seen_done++;
         @(posedge clk);
         #1;
      end
      chk("t4_stays_idle", seen_done, 0);

      // 6: back-to-back frames, second start on the cycle after done
      run_frame(0, 0, -1, -1, 0);
      check_frame("t6a", exp_x1, 21);
      run_frame(0, 0, -1, -1, 0);
      check_frame("t6b", exp_x1, 21);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
